parity_frame_tx: RTL and testbench

- Downstream stage of the 8-bit parity generator/checker.
- Accepts one byte plus its generated parity bit through a valid/ready handshake.
- Serialises the byte and parity into a fixed asynchronous-style frame on a single line: start bit, 8 data bits LSB first, parity bit, stop bit.
- The bit period is a parameterised number of clocks. The block feeds the lab's serial link or the receive-side checker.

---
 rtl/parity_frame_tx.sv | 156 +++++++++++++++
 tb/tb_parity_frame_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serialises a byte plus its parity bit as
// start(0), 8 data bits LSB first, parity, stop(1); each bit lasts
// CLKS_PER_BIT clocks. Every output comes straight from a register.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, ready to accept a byte/parity pair
// S_START  | start bit (0) on the line
// S_DATA   | data bits, LSB first, r_bit_cnt selects 0..7
// S_PARITY | latched parity bit on the line
// S_STOP   | stop bit (1); frame_done fires as it completes
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       parity_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state,   w_state_nx;
  logic [CW-1:0] r_clk_cnt, w_clk_cnt_nx;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nx;
  logic [7:0]    r_shift,   w_shift_nx;
  logic          r_par,     w_par_nx;
  logic          r_serial,  w_serial_nx;
  logic          r_ready,   w_ready_nx;
  logic          r_busy,    w_busy_nx;
  logic          r_done,    w_done_nx;
  logic          w_bit_end;

  // State and datapath registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_serial  <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_clk_cnt <= w_clk_cnt_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_shift   <= w_shift_nx;
      r_par     <= w_par_nx;
      r_serial  <= w_serial_nx;
      r_ready   <= w_ready_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    w_state_nx   = r_state;
    w_clk_cnt_nx = r_clk_cnt;
    w_bit_cnt_nx = r_bit_cnt;
    w_shift_nx   = r_shift;
    w_par_nx     = r_par;
    w_serial_nx  = r_serial;
    w_ready_nx   = r_ready;
    w_busy_nx    = r_busy;
    w_done_nx    = 1'b0;
    w_bit_end    = (r_clk_cnt == LAST);

    if (r_state != S_IDLE) begin
      w_clk_cnt_nx = w_bit_end ? '0 : r_clk_cnt + CW'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_serial_nx  = 1'b1;
        w_ready_nx   = 1'b1;
        w_busy_nx    = 1'b0;
        w_clk_cnt_nx = '0;
        w_bit_cnt_nx = '0;
        if (tx_valid) begin
          w_shift_nx  = data_in;
          w_par_nx    = parity_in;
          w_state_nx  = S_START;
          w_serial_nx = 1'b0;
          w_ready_nx  = 1'b0;
          w_busy_nx   = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nx   = S_DATA;
          w_bit_cnt_nx = '0;
          w_serial_nx  = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 3'd7) begin
            w_state_nx  = S_PARITY;
            w_serial_nx = r_par;
          end else begin
            // Shift so the next data bit is always at r_shift[0].
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            w_shift_nx   = r_shift >> 1;
            w_serial_nx  = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nx  = S_STOP;
          w_serial_nx = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nx   = S_IDLE;
          w_serial_nx  = 1'b1;
          w_ready_nx   = 1'b1;
          w_busy_nx    = 1'b0;
          w_done_nx    = 1'b1;
          w_bit_cnt_nx = '0;
        end
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_serial_nx = 1'b1;
        w_ready_nx  = 1'b1;
        w_busy_nx   = 1'b0;
      end
    endcase
  end

  assign tx_ready   = r_ready;
  assign serial_out = r_serial;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench for parity_frame_tx with a C=4 and a C=1 instance.
// Stimulus pushes hand-written expected frames ({stop,parity,data,start},
// start in bit 0); a monitor per instance captures each frame off the
// line, checks bit widths, busy/ready/frame_done timing and pops to compare.
module tb_parity_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst4 = 1'b1, rst1 = 1'b1;
  logic [7:0] data4 = 8'h00, data1 = 8'h00;
  logic       par4 = 1'b0, par1 = 1'b0;
  logic       valid4 = 1'b0, valid1 = 1'b0;
  logic       rdy4, ser4, busy4, done4;
  logic       rdy1, ser1, busy1, done1;

  parity_frame_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst4), .data_in(data4), .parity_in(par4),
    .tx_valid(valid4), .tx_ready(rdy4), .serial_out(ser4),
    .busy(busy4), .frame_done(done4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .data_in(data1), .parity_in(par1),
    .tx_valid(valid1), .tx_ready(rdy1), .serial_out(ser1),
    .busy(busy1), .frame_done(done1)
  );

  typedef struct {
    logic [10:0] bits;
    int          gap;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic ser_of(input int w);
    return (w == 1) ? ser1 : ser4;
  endfunction
  function automatic logic rst_of(input int w);
    return (w == 1) ? rst1 : rst4;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 1) ? busy1 : busy4;
  endfunction
  function automatic logic rdy_of(input int w);
    return (w == 1) ? rdy1 : rdy4;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 1) ? done1 : done4;
  endfunction

  task automatic monitor(input int w, input int c);
    logic [10:0] got;
    logic        held, busy_ok, abort, chk_lo;
    int          t0, last_start;
    exp_t        e;
    chk_lo     = 1'b0;
    last_start = -1;
    forever begin
      @(negedge clk);
      if (chk_lo) begin
        check_eq($sformatf("done_width_c%0d", c), {31'd0, done_of(w)}, 32'd0);
        chk_lo = 1'b0;
      end
      if (rst_of(w) === 1'b0 && ser_of(w) === 1'b0) begin
        t0      = cyc;
        got     = '0;
        held    = 1'b1;
        busy_ok = 1'b1;
        abort   = 1'b0;
        for (int t = 0; t < 11 * c; t++) begin
          if (t > 0) @(negedge clk);
          if (rst_of(w) !== 1'b0) begin
            abort = 1'b1;
            break;
          end
          if (t % c == 0) got[t / c] = ser_of(w);
          else if (ser_of(w) !== got[t / c]) held = 1'b0;
          if (busy_of(w) !== 1'b1 || rdy_of(w) !== 1'b0 || done_of(w) !== 1'b0)
            busy_ok = 1'b0;
        end
        if (!abort) begin
          @(negedge clk);
          check_eq($sformatf("frame_end_c%0d", c),
                   {28'd0, done_of(w), busy_of(w), rdy_of(w), ser_of(w)}, 32'b1011);
          chk_lo = 1'b1;
          check_eq($sformatf("bit_hold_c%0d", c), {31'd0, held}, 32'd1);
          check_eq($sformatf("busy_span_c%0d", c), {31'd0, busy_ok}, 32'd1);
          if ((w == 1 ? q1.size() : q4.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame_c%0d: actual=%0h required=none", c, got);
          end else begin
            e = (w == 1) ? q1.pop_front() : q4.pop_front();
            check_eq($sformatf("frame_bits_c%0d", c), {21'd0, got}, {21'd0, e.bits});
            if (e.gap > 0)
              check_eq($sformatf("start_gap_c%0d", c), t0 - last_start, e.gap);
          end
          last_start = t0;
        end
      end
    end
  endtask

  initial monitor(4, 4);
  initial monitor(1, 1);

  task automatic send4(input logic [7:0] d, input logic p, input logic [10:0] bits);
    q4.push_back('{bits, 0});
    data4  = d;
    par4   = p;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic saw_done;
    // Reset held 3 clocks; DUT1 also has tx_valid high through reset.
    data1  = 8'hA5;
    par1   = 1'b0;
    valid1 = 1'b1;
    q1.push_back('{11'b1_0_10100101_0, 0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_serial", {31'd0, ser4}, 32'd1);
    check_eq("rst_ready", {31'd0, rdy4}, 32'd1);
    check_eq("rst_busy", {31'd0, busy4}, 32'd0);
    check_eq("rst_done", {31'd0, done4}, 32'd0);
    rst4 = 1'b0;
    rst1 = 1'b0;

    // C=1: accept on the first edge after reset release.
    @(negedge clk);
    check_eq("first_accept_c1", {31'd0, ser1}, 32'd0);
    valid1 = 1'b0;

    // C=4 single frame 0x55 / parity 1.
    send4(8'h55, 1'b1, 11'b1_1_01010101_0);
    repeat (50) @(negedge clk);

    // Data/parity/valid change mid-frame must not disturb the latched frame.
    send4(8'h00, 1'b1, 11'b1_1_00000000_0);
    repeat (9) @(negedge clk);
    data4  = 8'hFF;
    par4   = 1'b0;
    valid4 = 1'b1;
    repeat (20) @(negedge clk);
    valid4 = 1'b0;
    data4  = 8'h00;
    repeat (25) @(negedge clk);

    // Back-to-back with tx_valid held high.
    q4.push_back('{11'b1_1_00001111_0, 0});
    data4  = 8'h0F;
    par4   = 1'b1;
    valid4 = 1'b1;
    @(negedge clk);
    q4.push_back('{11'b1_1_11110000_0, 45});
    data4 = 8'hF0;
    repeat (45) @(negedge clk);
    valid4 = 1'b0;
    repeat (50) @(negedge clk);

    // Reset during DATA bit 3 of a 0x00 frame (not scoreboarded: aborted).
    data4  = 8'h00;
    par4   = 1'b1;
    valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    check_eq("pre_abort_serial", {31'd0, ser4}, 32'd0);
    rst4 = 1'b1;
    #1;
    check_eq("abort_serial", {31'd0, ser4}, 32'd1);
    check_eq("abort_busy", {31'd0, busy4}, 32'd0);
    check_eq("abort_ready", {31'd0, rdy4}, 32'd1);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_done = saw_done | done4;
    end
    rst4 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_done = saw_done | done4;
    end
    check_eq("no_done_after_abort", {31'd0, saw_done}, 32'd0);

    send4(8'h3C, 1'b1, 11'b1_1_00111100_0);
    repeat (50) @(negedge clk);

    check_eq("q4_drained", q4.size(), 32'd0);
    check_eq("q1_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
